// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin pick of one finished unit result per cycle onto a registered CDB.
// grant doubles as each unit's *_wr_written, so it is combinational and same-cycle.
module cdb_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int ROB_IDX_W = 5,
   parameter int XLEN      = 32
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ*ROB_IDX_W-1:0]   req_rob_idx,
   input  logic [NUM_REQ*XLEN-1:0]        req_value,
   input  logic                           cdb_ready,
   input  logic                           flush,
   output logic [NUM_REQ-1:0]             grant,
   output logic                           cdb_valid,
   output logic [ROB_IDX_W-1:0]           cdb_rob_idx,
   output logic [XLEN-1:0]                cdb_value
);
   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   logic [PW-1:0]        rr_ptr, rr_next, scan;
   logic [ROB_IDX_W-1:0] sel_tag;
   logic [XLEN-1:0]      sel_value;
   logic                 accept, any_grant;
   assign accept = ~cdb_valid | cdb_ready;
   // Scan starts at rr_ptr and wraps; first requester found wins.
   always_comb begin
      grant     = '0;
      any_grant = 1'b0;
      scan      = '0;
      if (!reset && !flush && accept) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            scan = PW'((int'(rr_ptr) + k) % NUM_REQ);
            if (!any_grant && req_valid[scan]) begin
               grant[scan] = 1'b1;
               any_grant   = 1'b1;
            end
         end
      end
   end
   always_comb begin
      sel_tag   = '0;
      sel_value = '0;
      rr_next   = rr_ptr;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (grant[k]) begin
            sel_tag   = req_rob_idx[k*ROB_IDX_W +: ROB_IDX_W];
            sel_value = req_value[k*XLEN +: XLEN];
            rr_next   = PW'((k + 1) % NUM_REQ);
         end
      end
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         rr_ptr      <= '0;
         cdb_valid   <= 1'b0;
         cdb_rob_idx <= '0;
         cdb_value   <= '0;
      end else if (flush) begin
         cdb_valid <= 1'b0;
      end else if (any_grant) begin
         cdb_valid   <= 1'b1;
         cdb_rob_idx <= sel_tag;
         cdb_value   <= sel_value;
         rr_ptr      <= rr_next;
      end else if (accept) begin
         cdb_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed scenarios with a scoreboard of granted results versus CDB handshakes.
module tb_cdb_arbiter;
   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic [3:0]   req_valid = '0;
   logic [19:0]  req_rob_idx = '0;
   logic [127:0] req_value = '0;
   logic         cdb_ready = 1'b1;
   logic         flush = 1'b0;
   logic [3:0]   grant;
   logic         cdb_valid;
   logic [4:0]   cdb_rob_idx;
   logic [31:0]  cdb_value;
   int           total = 0;
   int           bad = 0;
   logic [36:0]  q[$];
   logic [36:0]  exp_item;

   cdb_arbiter dut (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_rob_idx(req_rob_idx),
      .req_value(req_value), .cdb_ready(cdb_ready), .flush(flush), .grant(grant),
      .cdb_valid(cdb_valid), .cdb_rob_idx(cdb_rob_idx), .cdb_value(cdb_value)
   );

   always #5 clock = ~clock;

   // Push each granted slice; pop on every accepted CDB beat.
   always @(negedge clock) begin
      if (!reset) begin
         total++;
         if (!$onehot0(grant) || (grant & ~req_valid) != 4'b0) begin
            bad++;
            $display("FAIL grant_legal grant=%b req_valid=%b", grant, req_valid);
         end
         if (cdb_valid && cdb_ready) begin
            total++;
            if (q.size() == 0) begin
               bad++;
               $display("FAIL sb_unexpected got tag=%0d value=%h, expected nothing", cdb_rob_idx, cdb_value);
            end else begin
               exp_item = q.pop_front();
               if ({cdb_rob_idx, cdb_value} !== exp_item) begin
                  bad++;
                  $display("FAIL sb_data got tag=%0d value=%h expected tag=%0d value=%h",
                           cdb_rob_idx, cdb_value, exp_item[36:32], exp_item[31:0]);
               end
            end
         end
         for (int i = 0; i < 4; i++)
            if (grant[i]) q.push_back({req_rob_idx[i*5 +: 5], req_value[i*32 +: 32]});
      end
   end

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic set_slot(input int i, input logic [4:0] t, input logic [31:0] v);
      req_rob_idx[i*5 +: 5] = t;
      req_value[i*32 +: 32] = v;
   endtask

   task automatic test_reset();
      reset = 1'b1; req_valid = 4'b1111; cdb_ready = 1'b1; flush = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clock);
         total++;
         if (grant !== 4'b0000) begin bad++; $display("FAIL reset_grant got=%b expected=0000", grant); end
      end
      next_cycle();
      reset = 1'b0; req_valid = 4'b0000;
      @(negedge clock);
      total += 3;
      if (cdb_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b expected=0", cdb_valid); end
      if (cdb_value !== 32'h0) begin bad++; $display("FAIL reset_value got=%h expected=0", cdb_value); end
      if (cdb_rob_idx !== 5'd0) begin bad++; $display("FAIL reset_tag got=%0d expected=0", cdb_rob_idx); end
      next_cycle();
   endtask

   task automatic test_single();
      set_slot(2, 5'd5, 32'hDEAD);
      req_valid = 4'b0100;
      @(negedge clock);
      total++;
      if (grant !== 4'b0100) begin bad++; $display("FAIL single_grant got=%b expected=0100", grant); end
      next_cycle();
      set_slot(0, 5'd1, 32'h1111_0000);
      set_slot(3, 5'd9, 32'h3333_0000);
      req_valid = 4'b1001;
      @(negedge clock);
      total += 4;
      if (cdb_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b expected=1", cdb_valid); end
      if (cdb_rob_idx !== 5'd5) begin bad++; $display("FAIL single_tag got=%0d expected=5", cdb_rob_idx); end
      if (cdb_value !== 32'hDEAD) begin bad++; $display("FAIL single_value got=%h expected=0000dead", cdb_value); end
      if (grant !== 4'b1000) begin bad++; $display("FAIL single_ptr3 got=%b expected=1000", grant); end
      next_cycle();
   endtask

   task automatic test_round_robin();
      logic [3:0] e;
      for (int c = 0; c < 8; c++) begin
         for (int i = 0; i < 4; i++) set_slot(i, 5'(c * 4 + i), $urandom);
         req_valid = 4'b1111;
         e = 4'b0001 << (c % 4);
         @(negedge clock);
         total++;
         if (grant !== e) begin bad++; $display("FAIL rr_grant cycle=%0d got=%b expected=%b", c, grant, e); end
         next_cycle();
      end
   endtask

   task automatic test_backpressure();
      cdb_ready = 1'b0;
      req_valid = 4'b0011;
      set_slot(0, 5'd17, 32'hCAFE_0000);
      set_slot(1, 5'd18, 32'hCAFE_0001);
      for (int c = 0; c < 3; c++) begin
         @(negedge clock);
         total += 3;
         if (grant !== 4'b0000) begin bad++; $display("FAIL bp_grant got=%b expected=0000", grant); end
         if (cdb_valid !== 1'b1) begin bad++; $display("FAIL bp_valid got=%b expected=1", cdb_valid); end
         if (q.size() == 0 || {cdb_rob_idx, cdb_value} !== q[0]) begin
            bad++; $display("FAIL bp_hold got tag=%0d value=%h queue_depth=%0d", cdb_rob_idx, cdb_value, q.size());
         end
         next_cycle();
      end
      cdb_ready = 1'b1;
      @(negedge clock);
      total++;
      if (grant !== 4'b0001) begin bad++; $display("FAIL bp_release got=%b expected=0001", grant); end
      next_cycle();
      req_valid = 4'b0000;
      @(negedge clock);
      total += 3;
      if (cdb_valid !== 1'b1) begin bad++; $display("FAIL bp_new_valid got=%b expected=1", cdb_valid); end
      if (cdb_rob_idx !== 5'd17) begin bad++; $display("FAIL bp_new_tag got=%0d expected=17", cdb_rob_idx); end
      if (cdb_value !== 32'hCAFE_0000) begin bad++; $display("FAIL bp_new_value got=%h expected=cafe0000", cdb_value); end
      next_cycle();
   endtask

   task automatic test_flush();
      set_slot(1, 5'd21, 32'h0BAD_F00D);
      req_valid = 4'b0010;
      @(negedge clock);
      total++;
      if (grant !== 4'b0010) begin bad++; $display("FAIL flush_setup got=%b expected=0010", grant); end
      next_cycle();
      flush = 1'b1; cdb_ready = 1'b0; req_valid = 4'b1000;
      set_slot(3, 5'd23, 32'h3000_0003);
      @(negedge clock);
      total++;
      if (grant !== 4'b0000) begin bad++; $display("FAIL flush_grant got=%b expected=0000", grant); end
      next_cycle();
      total++;
      if (q.size() != 1) begin bad++; $display("FAIL flush_queue got=%0d expected=1", q.size()); end
      q.delete();
      flush = 1'b0; cdb_ready = 1'b1; req_valid = 4'b1100;
      set_slot(2, 5'd22, 32'h2000_0002);
      @(negedge clock);
      total += 2;
      if (cdb_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b expected=0", cdb_valid); end
      if (grant !== 4'b0100) begin bad++; $display("FAIL flush_ptr_hold got=%b expected=0100", grant); end
      next_cycle();
   endtask

   task automatic test_wrap();
      set_slot(0, 5'd30, 32'hAAAA_0000);
      req_valid = 4'b0001;
      @(negedge clock);
      total++;
      if (grant !== 4'b0001) begin bad++; $display("FAIL wrap_grant got=%b expected=0001", grant); end
      next_cycle();
      set_slot(0, 5'd31, 32'hAAAA_0001);
      set_slot(1, 5'd29, 32'hBBBB_0001);
      req_valid = 4'b0011;
      @(negedge clock);
      total++;
      if (grant !== 4'b0010) begin bad++; $display("FAIL wrap_ptr1 got=%b expected=0010", grant); end
      next_cycle();
   endtask

   task automatic test_reset_mid();
      reset = 1'b1; req_valid = 4'b1111;
      @(negedge clock);
      total++;
      if (grant !== 4'b0000) begin bad++; $display("FAIL midreset_grant got=%b expected=0000", grant); end
      next_cycle();
      q.delete();
      reset = 1'b0;
      @(negedge clock);
      total += 2;
      if (cdb_valid !== 1'b0) begin bad++; $display("FAIL midreset_valid got=%b expected=0", cdb_valid); end
      if (grant !== 4'b0001) begin bad++; $display("FAIL midreset_ptr got=%b expected=0001", grant); end
      next_cycle();
   endtask

   task automatic test_drain();
      req_valid = 4'b0000; cdb_ready = 1'b1;
      next_cycle();
      next_cycle();
      total++;
      if (q.size() != 0) begin bad++; $display("FAIL drain_queue got=%0d expected=0", q.size()); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_flush();
      test_wrap();
      test_reset_mid();
      test_drain();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
